bus_datos_responder: RTL and testbench

- Data-bus responder for the 8-bit UAZ micro: the memory/peripheral end of the micro's data address, data-out and RW lines.
- Returns read data on the bus that feeds the micro's data-in input.
- Decodes a 256-byte space: general-purpose RAM, an 8-bit output port, a synchronized input port, and an 8-bit prescaled timer with overflow flag.
- Sits beside the micro at top level, on the same clock.

---
 rtl/bus_datos_responder.sv | 172 +++++++++++++++++
 tb/tb_bus_datos_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_datos_responder.sv
// -----------------------------------------------------------------------------
// bus_datos_responder
//
// Memory/peripheral end of the UAZ micro's data bus. It decodes a 256-byte
// data space into general-purpose RAM, an output port, a synchronized input
// port and an 8-bit prescaled timer with a sticky overflow flag. Read data is
// registered and returned to the micro on o_Dato_Bus.
//
// Bus protocol: there is no handshake. Every rising edge of i_Clk is one bus
// cycle. With i_RW=1 the addressed location takes i_DataOut_Bus at the edge and
// o_Dato_Bus holds. With i_RW=0, o_Dato_Bus takes the addressed location's
// pre-edge value at the edge (exactly one cycle of read latency).
//
// Ports:
//   i_Clk              system clock, rising edge
//   i_Reset            synchronous, active-high reset
//   i_Addres_Data_Bus  data address from the micro
//   i_DataOut_Bus      write data from the micro
//   i_RW               1 = write, 0 = read
//   o_Dato_Bus         registered read data to the micro
//   i_Puerto_In        asynchronous external input pins
//   o_Puerto_Out       output port register
//   o_Timer_Flag       sticky timer overflow flag
//
// Address map:
//   0x00..RAM_TOP  RAM
//   0xF0 PORT_OUT  0xF1 PORT_IN (read-only)  0xF2 TIMER_CNT
//   0xF3 TIMER_PRE 0xF4 CTRL {6'b0, flag, EN}
//   anything else reads 0x00, writes ignored
// -----------------------------------------------------------------------------
module bus_datos_responder #(
    parameter logic [7:0] RAM_TOP     = 8'hEF,
    parameter logic [7:0] PRE_RESET   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [7:0] i_Addres_Data_Bus,
    input  logic [7:0] i_DataOut_Bus,
    input  logic       i_RW,
    output logic [7:0] o_Dato_Bus,
    input  logic [7:0] i_Puerto_In,
    output logic [7:0] o_Puerto_Out,
    output logic       o_Timer_Flag
);

    localparam logic [7:0] ADDR_PORT_OUT  = 8'hF0;
    localparam logic [7:0] ADDR_PORT_IN   = 8'hF1;
    localparam logic [7:0] ADDR_TIMER_CNT = 8'hF2;
    localparam logic [7:0] ADDR_TIMER_PRE = 8'hF3;
    localparam logic [7:0] ADDR_CTRL      = 8'hF4;

    logic [7:0] dato_q, dato_d;
    logic [7:0] port_out_q, port_out_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] pre_q, pre_d;
    logic [7:0] presc_q, presc_d;
    logic       en_q, en_d;
    logic       flag_q, flag_d;

    // sync_q[0] is the first stage, sync_q[SYNC_STAGES-1] the one software sees.
    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;

    logic [7:0] ram_q [0:RAM_TOP];

    logic       ram_sel;
    logic       cnt_wr;
    logic       tick;
    logic [7:0] rdata;

    assign ram_sel = (i_Addres_Data_Bus <= RAM_TOP);
    assign cnt_wr  = i_RW && (i_Addres_Data_Bus == ADDR_TIMER_CNT);
    // Equality match only: a prescaler already past a newly written reload
    // value must wrap through 0xFF before it can match again.
    assign tick    = en_q && (presc_q == pre_q);

    // Read mux over pre-edge state.
    always_comb begin
        rdata = 8'h00;
        if (ram_sel) begin
            rdata = ram_q[i_Addres_Data_Bus];
        end else begin
            case (i_Addres_Data_Bus)
                ADDR_PORT_OUT:  rdata = port_out_q;
                ADDR_PORT_IN:   rdata = sync_q[SYNC_STAGES-1];
                ADDR_TIMER_CNT: rdata = cnt_q;
                ADDR_TIMER_PRE: rdata = pre_q;
                ADDR_CTRL:      rdata = {6'b0, flag_q, en_q};
                default:        rdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        dato_d     = dato_q;
        port_out_d = port_out_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        presc_d    = presc_q;
        en_d       = en_q;
        flag_d     = flag_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], i_Puerto_In};

        if (!i_RW) begin
            dato_d = rdata;
        end

        // CPU register writes. The flag clear is applied before the timer
        // below so that a coincident wrap overrides it.
        if (i_RW) begin
            case (i_Addres_Data_Bus)
                ADDR_PORT_OUT:  port_out_d = i_DataOut_Bus;
                ADDR_TIMER_CNT: cnt_d      = i_DataOut_Bus;
                ADDR_TIMER_PRE: pre_d      = i_DataOut_Bus;
                ADDR_CTRL: begin
                    en_d = i_DataOut_Bus[0];
                    if (i_DataOut_Bus[1]) begin
                        flag_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (en_q) begin
            presc_d = tick ? 8'h00 : presc_q + 8'h01;
        end

        // A CPU write to TIMER_CNT swallows a coincident tick, including
        // the flag that tick would have raised.
        if (tick && !cnt_wr) begin
            cnt_d = cnt_q + 8'h01;
            if (cnt_q == 8'hFF) begin
                flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            dato_q     <= 8'h00;
            port_out_q <= 8'h00;
            cnt_q      <= 8'h00;
            pre_q      <= PRE_RESET;
            presc_q    <= 8'h00;
            en_q       <= 1'b0;
            flag_q     <= 1'b0;
            sync_q     <= '0;
        end else begin
            dato_q     <= dato_d;
            port_out_q <= port_out_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            presc_q    <= presc_d;
            en_q       <= en_d;
            flag_q     <= flag_d;
            sync_q     <= sync_d;
        end
    end

    // RAM keeps its contents through reset, but reset still blocks a write.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset && i_RW && ram_sel) begin
            ram_q[i_Addres_Data_Bus] <= i_DataOut_Bus;
        end
    end

    assign o_Dato_Bus   = dato_q;
    assign o_Puerto_Out = port_out_q;
    assign o_Timer_Flag = flag_q;

endmodule

// File: tb/tb_bus_datos_responder.sv
module tb_bus_datos_responder;

    localparam logic [7:0] RAM_TOP     = 8'hEF;
    localparam logic [7:0] PRE_RESET   = 8'h5C;
    localparam int         SYNC_STAGES = 2;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       i_Reset = 1'b0;
    logic [7:0] i_Addres_Data_Bus = 8'h00;
    logic [7:0] i_DataOut_Bus = 8'h00;
    logic       i_RW = 1'b0;
    logic [7:0] o_Dato_Bus;
    logic [7:0] i_Puerto_In = 8'h00;
    logic [7:0] o_Puerto_Out;
    logic       o_Timer_Flag;

    always #5 clk = ~clk;

    bus_datos_responder #(
        .RAM_TOP(RAM_TOP),
        .PRE_RESET(PRE_RESET),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_Clk(clk),
        .i_Reset(i_Reset),
        .i_Addres_Data_Bus(i_Addres_Data_Bus),
        .i_DataOut_Bus(i_DataOut_Bus),
        .i_RW(i_RW),
        .o_Dato_Bus(o_Dato_Bus),
        .i_Puerto_In(i_Puerto_In),
        .o_Puerto_Out(o_Puerto_Out),
        .o_Timer_Flag(o_Timer_Flag)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] pin_v = 8'h00;

    // ---------------- reference model ----------------
    // Register-level view of the address map, advanced once per bus cycle.
    logic [7:0] m_ram [0:255];
    logic [7:0] m_port, m_cnt, m_pre, m_presc, m_dato;
    logic       m_en, m_flag;
    logic [7:0] m_pin_q [$];   // pin samples still travelling through the synchronizer

    function automatic logic [7:0] model_read(input logic [7:0] a, input logic [7:0] visible_pin);
        if (a <= RAM_TOP) return m_ram[a];
        case (a)
            8'hF0:   return m_port;
            8'hF1:   return visible_pin;
            8'hF2:   return m_cnt;
            8'hF3:   return m_pre;
            8'hF4:   return {6'b0, m_flag, m_en};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic rw, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] pin);
        logic [7:0] visible;
        logic       ticked;
        logic       cnt_written;
        if (rst) begin
            m_dato = 0; m_port = 0; m_cnt = 0; m_presc = 0;
            m_en = 0; m_flag = 0; m_pre = PRE_RESET;
            m_pin_q.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_pin_q.push_back(8'h00);
            return;
        end
        visible = m_pin_q[0];
        if (!rw) m_dato = model_read(a, visible);
        cnt_written = rw && (a == 8'hF2);
        ticked = 1'b0;
        if (m_en) begin
            if (m_presc == m_pre) begin
                m_presc = 0;
                ticked = 1'b1;
            end else begin
                m_presc = m_presc + 1;
            end
        end
        if (rw && a == 8'hF4 && d[1]) m_flag = 1'b0;
        if (ticked && !cnt_written && m_cnt == 8'hFF) m_flag = 1'b1;
        if (ticked && !cnt_written) m_cnt = m_cnt + 1;
        if (rw) begin
            if (a <= RAM_TOP) m_ram[a] = d;
            case (a)
                8'hF0: m_port = d;
                8'hF2: m_cnt  = d;
                8'hF3: m_pre  = d;
                8'hF4: m_en   = d[0];
                default: ;
            endcase
        end
        void'(m_pin_q.pop_front());
        m_pin_q.push_back(pin);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic rst, input logic rw, input logic [7:0] a, input logic [7:0] d);
        i_Reset = rst;
        i_RW = rw;
        i_Addres_Data_Bus = a;
        i_DataOut_Bus = d;
        i_Puerto_In = pin_v;
        @(posedge clk);
        model_edge(rst, rw, a, d, pin_v);
        #1;
        i_Reset = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        step(1'b0, 1'b0, a, 8'h00);
        chk(name, o_Dato_Bus, exp);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] pin;
        logic [7:0] exp_dato;
        logic [7:0] exp_port;
        logic       exp_flag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rw, input logic [7:0] a, input logic [7:0] d,
                                input logic [7:0] pin, input logic [7:0] ed,
                                input logic [7:0] ep, input logic ef);
        vec_t v;
        v.rw = rw; v.addr = a; v.wdata = d; v.pin = pin;
        v.exp_dato = ed; v.exp_port = ep; v.exp_flag = ef;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rw    addr   wdata  pin    dato   port   flag
        vecs.push_back(mk(1'b0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF3, 8'h00, 8'h00, PRE_RESET, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 8'h10, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, RAM_TOP, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, RAM_TOP, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF7, 8'h33, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        vecs.push_back(mk(1'b0, 8'h10, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF0, 8'h3C, 8'h00, 8'h5A, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF0, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF1, 8'hFF, 8'h00, 8'h3C, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF1, 8'h00, 8'h81, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF1, 8'h00, 8'h81, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF1, 8'h00, 8'h81, 8'h81, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF3, 8'h07, 8'h81, 8'h81, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF3, 8'h00, 8'h81, 8'h07, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b1, 8'hF4, 8'hFC, 8'h81, 8'h07, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'hF4, 8'h00, 8'h81, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b1, 8'hFF, 8'h12, 8'h81, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'hFF, 8'h00, 8'h81, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b1, 8'h20, 8'hC3, 8'h81, 8'h00, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 8'h20, 8'h00, 8'h81, 8'hC3, 8'h3C, 1'b0));

        // Reset state straight after the reset cycle.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        chk("reset_dato", o_Dato_Bus, 8'h00);
        chk("reset_port", o_Puerto_Out, 8'h00);
        chk("reset_flag", {7'b0, o_Timer_Flag}, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            pin_v = vecs[i].pin;
            step(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_dato", i), o_Dato_Bus, vecs[i].exp_dato);
            chk($sformatf("vec%0d_port", i), o_Puerto_Out, vecs[i].exp_port);
            chk($sformatf("vec%0d_flag", i), {7'b0, o_Timer_Flag}, {7'b0, vecs[i].exp_flag});
        end

        // Prescaled count and wrap: PRE=3 gives one increment per 4 cycles.
        wr(8'hF3, 8'h03);
        wr(8'hF2, 8'hFE);
        wr(8'hF4, 8'h01);
        for (int k = 1; k <= 9; k++) begin
            rd(8'hF2, (k <= 4) ? 8'hFE : ((k <= 8) ? 8'hFF : 8'h00), $sformatf("pre3_cnt_k%0d", k));
            chk($sformatf("pre3_flag_k%0d", k), {7'b0, o_Timer_Flag}, (k >= 8) ? 8'h01 : 8'h00);
        end
        rd(8'hF4, 8'h03, "ctrl_flag_en");
        wr(8'hF4, 8'h02);
        chk("flag_clear", {7'b0, o_Timer_Flag}, 8'h00);
        rd(8'hF4, 8'h00, "ctrl_after_clear");

        // PRE=0, write to TIMER_CNT in a tick cycle, wrap vs clear.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        wr(8'hF3, 8'h00);
        wr(8'hF4, 8'h01);
        rd(8'hF2, 8'h00, "pre0_first");
        wr(8'hF2, 8'h40);
        rd(8'hF2, 8'h40, "cnt_write_wins");
        rd(8'hF2, 8'h41, "cnt_after_write");
        wr(8'hF2, 8'hFD);
        rd(8'hF2, 8'hFD, "cnt_fd");
        rd(8'hF2, 8'hFE, "cnt_fe");
        wr(8'hF4, 8'h03);
        chk("wrap_beats_clear", {7'b0, o_Timer_Flag}, 8'h01);
        rd(8'hF4, 8'h03, "ctrl_after_wrap");
        wr(8'hF4, 8'h03);
        chk("clear_no_wrap", {7'b0, o_Timer_Flag}, 8'h00);
        wr(8'hF2, 8'hFE);
        rd(8'hF2, 8'hFE, "cnt_fe2");
        wr(8'hF2, 8'h22);
        chk("write_blocks_wrap_flag", {7'b0, o_Timer_Flag}, 8'h00);
        rd(8'hF2, 8'h22, "cnt_after_wrap_write");

        // TIMER_PRE lowered below a running prescaler: no match until it wraps.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        wr(8'hF3, 8'h05);
        wr(8'hF4, 8'h01);
        for (int k = 0; k < 3; k++) rd(8'hF2, 8'h00, "pre5_run");
        wr(8'hF3, 8'h02);
        for (int k = 0; k < 10; k++) rd(8'hF2, 8'h00, $sformatf("pre_lowered_k%0d", k));

        // Reset in the middle of a count.
        wr(8'hF2, 8'h77);
        rd(8'hF2, 8'h77, "cnt_77");
        step(1'b1, 1'b0, 8'hF2, 8'h00);
        chk("midreset_dato", o_Dato_Bus, 8'h00);
        chk("midreset_flag", {7'b0, o_Timer_Flag}, 8'h00);
        rd(8'hF2, 8'h00, "midreset_cnt");
        rd(8'hF4, 8'h00, "midreset_ctrl");
        rd(8'h10, 8'h5A, "ram_survives_reset");
        rd(8'hF3, PRE_RESET, "midreset_pre");
        rd(8'hF2, 8'h00, "midreset_frozen");

        // Randomized traffic against the model.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        for (int a = 0; a <= int'(RAM_TOP); a++) wr(8'(a), 8'($urandom));
        for (int n = 0; n < 2500; n++) begin
            logic       rw;
            logic       rst;
            logic [7:0] a;
            logic [7:0] d;
            int         sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3)      a = 8'($urandom_range(8'hF0, 8'hF4));
            else if (sel <= 6) a = 8'($urandom_range(0, int'(RAM_TOP)));
            else if (sel == 7) a = 8'($urandom_range(8'hF5, 8'hFF));
            else               a = (sel == 8) ? 8'hF2 : 8'hF4;
            rw  = ($urandom_range(0, 2) == 0);
            d   = (a == 8'hF3) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) pin_v = 8'($urandom);
            step(rst, rw, a, d);
            exp_q.push_back(m_dato);
            chk($sformatf("rand%0d_dato", n), o_Dato_Bus, exp_q.pop_front());
            chk($sformatf("rand%0d_port", n), o_Puerto_Out, m_port);
            chk($sformatf("rand%0d_flag", n), {7'b0, o_Timer_Flag}, {7'b0, m_flag});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
